// File: rtl/salida_acum.sv
// salida_acum: N-bit quotient-bit accumulator with fill count, done pulse and sticky protocol flags
module salida_acum #(
  parameter int N = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clr,
  input  logic [1:0]    i_a,
  output logic [N-1:0]  q,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_done,
  output logic          o_err,
  output logic          o_ovf
);
  typedef enum logic [1:0] {EMPTY, FILL, FULL} state_t;
  state_t        r_state;
  logic [N-1:0]  r_q;
  logic [CW-1:0] r_count;
  logic          r_done, r_err, r_ovf;
  logic          w_shift, w_last;
  logic [N-1:0]  w_q_next;
  // 2'b01 and 2'b10 are the only shift commands; i_a[0] is the shifted bit
  assign w_shift  = i_a[1] ^ i_a[0];
  assign w_last   = r_count == CW'(N - 1);
  assign w_q_next = MSB_FIRST ? {r_q[N-2:0], i_a[0]} : {i_a[0], r_q[N-1:1]};
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_state <= EMPTY;
      r_q     <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_a == 2'b11) r_err <= 1'b1;
      if (w_shift) begin
        if (r_state == FULL) r_ovf <= 1'b1;
        else begin
          r_q     <= w_q_next;
          r_count <= r_count + 1'b1;
          r_state <= w_last ? FULL : FILL;
          r_done  <= w_last;
        end
      end
    end
  end
  assign q       = r_q;
  assign o_count = r_count;
  assign o_full  = r_state == FULL;
  assign o_done  = r_done;
  assign o_err   = r_err;
  assign o_ovf   = r_ovf;
endmodule

// File: tb/tb_salida_acum.sv
// tb_salida_acum: MSB-first and LSB-first accumulators checked against a bit-list model
module tb_salida_acum;
  localparam int N = 8;
  logic clk = 1'b0, reset = 1'b1, i_clr = 1'b0;
  logic [1:0] i_a = 2'b00;
  logic [7:0] q1, q0;
  logic [3:0] c1, c0;
  logic f1, f0, d1, d0, e1, e0, v1, v0;
  int tests = 0, fails = 0;
  bit en = 1'b0;
  bit m_bits[$];
  bit m_done = 1'b0, m_err = 1'b0, m_ovf = 1'b0;

  salida_acum #(.N(N), .MSB_FIRST(1'b1)) u1 (.clk(clk), .reset(reset), .i_clr(i_clr), .i_a(i_a),
    .q(q1), .o_count(c1), .o_full(f1), .o_done(d1), .o_err(e1), .o_ovf(v1));
  salida_acum #(.N(N), .MSB_FIRST(1'b0)) u0 (.clk(clk), .reset(reset), .i_clr(i_clr), .i_a(i_a),
    .q(q0), .o_count(c0), .o_full(f0), .o_done(d0), .o_err(e0), .o_ovf(v0));

  always #5 clk = ~clk;

  // the result is a list of accepted bits; its placement in q depends only on order
  function automatic logic [7:0] mq(bit msb);
    logic [7:0] v = '0;
    int k = m_bits.size();
    for (int i = 0; i < k; i++)
      if (msb) v = {v[6:0], m_bits[i]};
      else if (m_bits[i]) v = v | (8'd1 << (N - k + i));
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset || i_clr) begin
      m_bits.delete();
      m_done = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
    end else begin
      m_done = 1'b0;
      if (i_a == 2'b11) m_err = 1'b1;
      else if (i_a != 2'b00) begin
        if (m_bits.size() == N) m_ovf = 1'b1;
        else begin
          m_bits.push_back(i_a == 2'b01);
          m_done = m_bits.size() == N;
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (en) begin
    chk("msb_q", {24'd0, q1}, {24'd0, mq(1'b1)});
    chk("lsb_q", {24'd0, q0}, {24'd0, mq(1'b0)});
    chk("msb_flags", {c1, f1, d1, e1, v1}, {4'(m_bits.size()), m_bits.size() == N, m_done, m_err, m_ovf});
    chk("lsb_flags", {c0, f0, d0, e0, v0}, {4'(m_bits.size()), m_bits.size() == N, m_done, m_err, m_ovf});
  end

  task automatic step(logic r, logic c, logic [1:0] a);
    reset = r; i_clr = c; i_a = a;
    @(negedge clk);
  endtask

  task automatic fill(logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(1'b0, 1'b0, v[i] ? 2'b01 : 2'b10);
  endtask

  task automatic zeros(string name);
    chk(name, {q1, q0, c1, c0, f1, f0, d1, d0, e1, e0, v1, v0}, '0);
  endtask

  initial begin
    @(negedge clk);
    en = 1'b1;
    zeros("reset_state");
    // MSB/LSB fill with done pulse
    step(1'b1, 1'b0, 2'b00);
    fill(8'hB2);
    chk("t1_q_msb", {24'd0, q1}, 32'hB2);
    chk("t2_q_lsb", {24'd0, q0}, 32'h4D);
    chk("t1_flags", {c1, f1, d1, e1, v1}, {4'd8, 4'b1100});
    // shift while full
    step(1'b0, 1'b0, 2'b01);
    chk("t4_full", {q1, c1, f1, d1, e1, v1}, {8'hB2, 4'd8, 4'b1001});
    // hold and illegal
    step(1'b1, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b01); step(1'b0, 1'b0, 2'b01);
    repeat (3) step(1'b0, 1'b0, 2'b00);
    step(1'b0, 1'b0, 2'b11);
    step(1'b0, 1'b0, 2'b10);
    chk("t3_hold_illegal", {q1, c1, f1, e1}, {8'h06, 4'd3, 1'b0, 1'b1});
    chk("t3_lsb_q", {24'd0, q0}, 32'h60);
    // clear with simultaneous shift, then fresh fill
    step(1'b1, 1'b0, 2'b00);
    repeat (4) step(1'b0, 1'b0, 2'b01);
    step(1'b0, 1'b1, 2'b01);
    zeros("t5_clear");
    fill(8'hC5);
    chk("t5_refill", {q1, q0, c1, d1}, {8'hC5, 8'hA3, 4'd8, 1'b1});
    // clear during done pulse
    step(1'b0, 1'b1, 2'b00);
    zeros("clr_on_done");
    // reset mid-fill, then reset with clear
    repeat (5) step(1'b0, 1'b0, 2'b01);
    step(1'b1, 1'b0, 2'b10);
    zeros("t6_reset");
    repeat (3) step(1'b0, 1'b0, 2'b10);
    step(1'b1, 1'b1, 2'b01);
    zeros("t6_reset_clr");
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0, 2'($urandom_range(0, 3)));
    en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
